// File: rtl/reg_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter_if : requester handshakes, register-file write drive, busy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef NumRegsWidth
`define NumRegsWidth 5
`endif
`ifndef NumRegs
`define NumRegs 32
`endif
`ifndef RegWidth
`define RegWidth 32
`endif

interface reg_write_arbiter_if;
  logic                     a_valid;
  logic                     a_ready;
  logic [`NumRegsWidth-1:0] a_rd;
  logic [`RegWidth-1:0]     a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [`NumRegsWidth-1:0] b_rd;
  logic [`RegWidth-1:0]     b_data;
  logic                     wr_en;
  logic [`NumRegsWidth-1:0] wr_rd;
  logic [`RegWidth-1:0]     wr_data;
  logic [`NumRegs-1:0]      busy;

  // Master side: both requesters plus the register file / hazard logic.
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, wr_en, wr_rd, wr_data, busy
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, wr_en, wr_rd, wr_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter : two-slot register-file write arbiter (A priority, same-rd
// ordering); starvation guard for B enabled by macro REG_WRITE_ARB_STARVE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef NumRegsWidth
`define NumRegsWidth 5
`endif
`ifndef NumRegs
`define NumRegs 32
`endif
`ifndef RegWidth
`define RegWidth 32
`endif

module reg_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input wire clk,
  input wire rst_n,
  reg_write_arbiter_if.slave bus
);

  localparam int C_RD_W = `NumRegsWidth;
  localparam int C_D_W  = `RegWidth;
  localparam int C_NREG = `NumRegs;

  logic              r_a_vld;
  logic [C_RD_W-1:0] r_a_rd;
  logic [C_D_W-1:0]  r_a_data;
  logic              r_b_vld;
  logic [C_RD_W-1:0] r_b_rd;
  logic [C_D_W-1:0]  r_b_data;
  logic              r_b_older;

  logic              r_wr_en;
  logic [C_RD_W-1:0] r_wr_rd;
  logic [C_D_W-1:0]  r_wr_data;

  logic              w_same_rd;
  logic              w_force_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_acc_a;
  logic              w_acc_b;
  logic [C_NREG-1:0] w_busy;

  assign w_same_rd = r_a_vld & r_b_vld & (r_a_rd == r_b_rd);

  // Same-rd ordering outranks the starvation override so writes to one
  // register always retire in acceptance order.
  always_comb begin
    w_grant_b = 1'b0;
    if (r_b_vld) begin
      if (!r_a_vld) begin
        w_grant_b = 1'b1;
      end else if (w_same_rd) begin
        w_grant_b = r_b_older;
      end else begin
        w_grant_b = w_force_b;
      end
    end
  end

  assign w_grant_a = r_a_vld & ~w_grant_b;
  assign w_a_ready = ~r_a_vld | w_grant_a;
  assign w_b_ready = ~r_b_vld | w_grant_b;
  assign w_acc_a   = bus.a_valid & w_a_ready;
  assign w_acc_b   = bus.b_valid & w_b_ready;

`ifdef REG_WRITE_ARB_STARVE_EN
  localparam int C_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [C_CNT_W-1:0] r_starve_cnt;

  assign w_force_b = (r_starve_cnt == C_CNT_W'(STARVE_LIMIT));

  // Saturates at the limit in case a same-rd ordering hold defers B further.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!r_b_vld || w_grant_b) begin
      r_starve_cnt <= '0;
    end else if (!w_force_b) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  logic w_unused_starve_limit;

  assign w_force_b             = 1'b0;
  assign w_unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_vld   <= 1'b0;
      r_a_rd    <= '0;
      r_a_data  <= '0;
      r_b_vld   <= 1'b0;
      r_b_rd    <= '0;
      r_b_data  <= '0;
      r_b_older <= 1'b0;
    end else begin
      if (w_acc_a) begin
        r_a_vld  <= 1'b1;
        r_a_rd   <= bus.a_rd;
        r_a_data <= bus.a_data;
      end else if (w_grant_a) begin
        r_a_vld  <= 1'b0;
      end

      if (w_acc_b) begin
        r_b_vld  <= 1'b1;
        r_b_rd   <= bus.b_rd;
        r_b_data <= bus.b_data;
      end else if (w_grant_b) begin
        r_b_vld  <= 1'b0;
      end

      // A newly accepted entry is always younger than one that stays held;
      // a simultaneous pair counts A as the older.
      if (w_acc_b) begin
        r_b_older <= 1'b0;
      end else if (w_acc_a) begin
        r_b_older <= r_b_vld & ~w_grant_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_grant_a | w_grant_b;
      if (w_grant_b) begin
        r_wr_rd   <= r_b_rd;
        r_wr_data <= r_b_data;
      end else if (w_grant_a) begin
        r_wr_rd   <= r_a_rd;
        r_wr_data <= r_a_data;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    if (r_a_vld) begin
      w_busy[r_a_rd] = 1'b1;
    end
    if (r_b_vld) begin
      w_busy[r_b_rd] = 1'b1;
    end
    if (r_wr_en) begin
      w_busy[r_wr_rd] = 1'b1;
    end
  end

  assign bus.a_ready = w_a_ready;
  assign bus.b_ready = w_b_ready;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_rd   = r_wr_rd;
  assign bus.wr_data = r_wr_data;
  assign bus.busy    = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter : directed scenarios plus randomized traffic checked
// against a sequence-numbered slot model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef NumRegsWidth
`define NumRegsWidth 5
`endif
`ifndef NumRegs
`define NumRegs 32
`endif
`ifndef RegWidth
`define RegWidth 32
`endif

module tb_reg_write_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int RDW   = `NumRegsWidth;
  localparam int DW    = `RegWidth;
  localparam int NREGS = `NumRegs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  reg_write_arbiter_if bus ();

  reg_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: each slot carries an acceptance sequence number.
  logic           m_a_vld, m_b_vld;
  logic [RDW-1:0] m_a_rd, m_b_rd;
  logic [DW-1:0]  m_a_data, m_b_data;
  int             m_a_seq, m_b_seq, m_seq, m_b_wait;
  logic           m_wr_en;
  logic [RDW-1:0] m_wr_rd;
  logic [DW-1:0]  m_wr_data;

  // 0: nothing, 1: A, 2: B
  function automatic int model_pick();
    if (!m_a_vld && !m_b_vld) return 0;
    if (!m_b_vld) return 1;
    if (!m_a_vld) return 2;
    if (m_a_rd == m_b_rd) return (m_b_seq < m_a_seq) ? 2 : 1;
`ifdef REG_WRITE_ARB_STARVE_EN
    if (m_b_wait >= STARVE_LIMIT) return 2;
`endif
    return 1;
  endfunction

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got=%0b exp=0", bus.wr_en); else n_pass++;
    n_checks++; if (bus.wr_rd !== '0) $display("FAIL reset_wr_rd got=%0d exp=0", bus.wr_rd); else n_pass++;
    n_checks++; if (bus.wr_data !== '0) $display("FAIL reset_wr_data got=%0h exp=0", bus.wr_data); else n_pass++;
    n_checks++; if (bus.busy !== '0) $display("FAIL reset_busy got=%0h exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL reset_a_ready got=%0b exp=1", bus.a_ready); else n_pass++;
    n_checks++; if (bus.b_ready !== 1'b1) $display("FAIL reset_b_ready got=%0b exp=1", bus.b_ready); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL reset_first_edge_wr_en got=%0b exp=0", bus.wr_en); else n_pass++;
  endtask

  task automatic test_single();
    bus.a_valid = 1'b1; bus.a_rd = RDW'(3); bus.a_data = DW'(32'h1234);
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL single_a_ready got=%0b exp=1", bus.a_ready); else n_pass++;
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL single_wr_en_c0 got=%0b exp=0", bus.wr_en); else n_pass++;
    n_checks++; if (bus.busy !== NREGS'(32'h8)) $display("FAIL single_busy_c0 got=%0h exp=8", bus.busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wr_en !== 1'b1) $display("FAIL single_wr_en got=%0b exp=1", bus.wr_en); else n_pass++;
    n_checks++; if (bus.wr_rd !== RDW'(3)) $display("FAIL single_wr_rd got=%0d exp=3", bus.wr_rd); else n_pass++;
    n_checks++; if (bus.wr_data !== DW'(32'h1234)) $display("FAIL single_wr_data got=%0h exp=1234", bus.wr_data); else n_pass++;
    n_checks++; if (bus.busy !== NREGS'(32'h8)) $display("FAIL single_busy_c1 got=%0h exp=8", bus.busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL single_wr_en_idle got=%0b exp=0", bus.wr_en); else n_pass++;
    n_checks++; if (bus.busy !== '0) $display("FAIL single_busy_c2 got=%0h exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.wr_rd !== RDW'(3)) $display("FAIL single_wr_rd_hold got=%0d exp=3", bus.wr_rd); else n_pass++;
  endtask

  task automatic test_contention();
    bus.a_valid = 1'b1; bus.a_rd = RDW'(1); bus.a_data = DW'(32'hA);
    bus.b_valid = 1'b1; bus.b_rd = RDW'(2); bus.b_data = DW'(32'hB);
    @(posedge clk); #1;
    idle_inputs();
    n_checks++; if (bus.b_ready !== 1'b0) $display("FAIL cont_b_ready got=%0b exp=0", bus.b_ready); else n_pass++;
    n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL cont_a_ready got=%0b exp=1", bus.a_ready); else n_pass++;
    n_checks++; if (bus.busy !== NREGS'(32'h6)) $display("FAIL cont_busy got=%0h exp=6", bus.busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({bus.wr_en, bus.wr_rd, bus.wr_data} !== {1'b1, RDW'(1), DW'(32'hA)})
      $display("FAIL cont_first got=%0b/%0d/%0h exp=1/1/a", bus.wr_en, bus.wr_rd, bus.wr_data); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({bus.wr_en, bus.wr_rd, bus.wr_data} !== {1'b1, RDW'(2), DW'(32'hB)})
      $display("FAIL cont_second got=%0b/%0d/%0h exp=1/2/b", bus.wr_en, bus.wr_rd, bus.wr_data); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL cont_idle got=%0b exp=0", bus.wr_en); else n_pass++;
  endtask

  task automatic test_same_rd();
    bus.a_valid = 1'b1; bus.a_rd = RDW'(7); bus.a_data = DW'(32'h77);
    bus.b_valid = 1'b1; bus.b_rd = RDW'(5); bus.b_data = DW'(32'h1);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    bus.a_rd = RDW'(5); bus.a_data = DW'(32'h2);
    n_checks++; if (bus.a_ready !== 1'b1) $display("FAIL samerd_a_ready got=%0b exp=1", bus.a_ready); else n_pass++;
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    n_checks++; if ({bus.wr_en, bus.wr_rd, bus.wr_data} !== {1'b1, RDW'(7), DW'(32'h77)})
      $display("FAIL samerd_w0 got=%0b/%0d/%0h exp=1/7/77", bus.wr_en, bus.wr_rd, bus.wr_data); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({bus.wr_en, bus.wr_rd, bus.wr_data} !== {1'b1, RDW'(5), DW'(32'h1)})
      $display("FAIL samerd_w1 got=%0b/%0d/%0h exp=1/5/1", bus.wr_en, bus.wr_rd, bus.wr_data); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({bus.wr_en, bus.wr_rd, bus.wr_data} !== {1'b1, RDW'(5), DW'(32'h2)})
      $display("FAIL samerd_w2 got=%0b/%0d/%0h exp=1/5/2", bus.wr_en, bus.wr_rd, bus.wr_data); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    int a_cnt = 0;
    int a_seen = 0;
    int b_pos = -1;
    int exp_pos;
    bit order_ok = 1'b1;
    bit acc_a, acc_b;
`ifdef REG_WRITE_ARB_STARVE_EN
    exp_pos = STARVE_LIMIT + 1;
`else
    exp_pos = 9;
`endif
    bus.a_valid = 1'b1; bus.a_rd = RDW'(1); bus.a_data = DW'(32'h100);
    bus.b_valid = 1'b1; bus.b_rd = RDW'(9); bus.b_data = DW'(32'hBBBB);
    for (int e = 0; e < 14; e++) begin
      #1;
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      @(posedge clk); #1;
      if (acc_a) a_cnt++;
      if (acc_b) bus.b_valid = 1'b0;
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_rd === RDW'(9)) begin
          b_pos = e;
        end else begin
          if (bus.wr_data !== DW'(32'h100 + a_seen)) order_ok = 1'b0;
          a_seen++;
        end
      end
      bus.a_valid = (a_cnt < 8);
      bus.a_data  = DW'(32'h100 + a_cnt);
    end
    idle_inputs();
    n_checks++; if (b_pos != exp_pos) $display("FAIL starve_b_edge got=%0d exp=%0d", b_pos, exp_pos); else n_pass++;
    n_checks++; if (a_seen != 8) $display("FAIL starve_a_writes got=%0d exp=8", a_seen); else n_pass++;
    n_checks++; if (!order_ok) $display("FAIL starve_a_order got=0 exp=1"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.a_valid = 1'b1; bus.a_rd = RDW'(1); bus.a_data = DW'(32'h11);
    bus.b_valid = 1'b1; bus.b_rd = RDW'(2); bus.b_data = DW'(32'h22);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    bus.a_rd = RDW'(3); bus.a_data = DW'(32'h33);
    @(posedge clk); #1;
    idle_inputs();
    n_checks++; if (bus.busy !== NREGS'(32'hE)) $display("FAIL rstmid_pre_busy got=%0h exp=e", bus.busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL rstmid_wr_en got=%0b exp=0", bus.wr_en); else n_pass++;
    n_checks++; if (bus.busy !== '0) $display("FAIL rstmid_busy got=%0h exp=0", bus.busy); else n_pass++;
    n_checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) $display("FAIL rstmid_ready got=%0b%0b exp=11", bus.a_ready, bus.b_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL rstmid_no_write[%0d] got=%0b exp=0", i, bus.wr_en); else n_pass++;
    end
  endtask

  task automatic test_random();
    int pick;
    bit va, vb, acc_a, acc_b;
    logic [NREGS-1:0] exp_busy;
    do_reset();
    m_a_vld = 1'b0; m_b_vld = 1'b0; m_seq = 0; m_b_wait = 0;
    m_wr_en = 1'b0; m_wr_rd = '0; m_wr_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      va = ($urandom_range(0, 99) < 60);
      vb = ($urandom_range(0, 99) < 60);
      bus.a_valid = va; bus.a_rd = RDW'($urandom_range(0, 3)); bus.a_data = DW'($urandom());
      bus.b_valid = vb; bus.b_rd = RDW'($urandom_range(0, 3)); bus.b_data = DW'($urandom());
      pick = model_pick();
      exp_busy = '0;
      for (int r = 0; r < NREGS; r++) begin
        if ((m_a_vld && m_a_rd == RDW'(r)) || (m_b_vld && m_b_rd == RDW'(r)) ||
            (m_wr_en && m_wr_rd == RDW'(r)))
          exp_busy[r] = 1'b1;
      end
      acc_a = va && (!m_a_vld || pick == 1);
      acc_b = vb && (!m_b_vld || pick == 2);
      #1;
      n_checks++; if (bus.a_ready !== (!m_a_vld || pick == 1)) $display("FAIL rnd_a_ready cyc=%0d got=%0b", cyc, bus.a_ready); else n_pass++;
      n_checks++; if (bus.b_ready !== (!m_b_vld || pick == 2)) $display("FAIL rnd_b_ready cyc=%0d got=%0b", cyc, bus.b_ready); else n_pass++;
      n_checks++; if (bus.busy !== exp_busy) $display("FAIL rnd_busy cyc=%0d got=%0h exp=%0h", cyc, bus.busy, exp_busy); else n_pass++;
      @(posedge clk); #1;
      if (m_b_vld && pick != 2) m_b_wait++; else m_b_wait = 0;
      m_wr_en = (pick != 0);
      if (pick == 1) begin m_wr_rd = m_a_rd; m_wr_data = m_a_data; m_a_vld = 1'b0; end
      if (pick == 2) begin m_wr_rd = m_b_rd; m_wr_data = m_b_data; m_b_vld = 1'b0; end
      if (acc_a) begin m_a_vld = 1'b1; m_a_rd = bus.a_rd; m_a_data = bus.a_data; m_a_seq = m_seq; m_seq++; end
      if (acc_b) begin m_b_vld = 1'b1; m_b_rd = bus.b_rd; m_b_data = bus.b_data; m_b_seq = m_seq; m_seq++; end
      n_checks++; if (bus.wr_en !== m_wr_en) $display("FAIL rnd_wr_en cyc=%0d got=%0b exp=%0b", cyc, bus.wr_en, m_wr_en); else n_pass++;
      n_checks++; if (bus.wr_rd !== m_wr_rd) $display("FAIL rnd_wr_rd cyc=%0d got=%0d exp=%0d", cyc, bus.wr_rd, m_wr_rd); else n_pass++;
      n_checks++; if (bus.wr_data !== m_wr_data) $display("FAIL rnd_wr_data cyc=%0d got=%0h exp=%0h", cyc, bus.wr_data, m_wr_data); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_same_rd();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost arbitrations after which requester B is forced to win.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port a_valid / a_ready  input / output  1 / 1  handshake for requester A (ALU write-back).
REQ-005 SHALL have port a_rd / a_data  input  `NumRegsWidth / `RegWidth  A's destination register and value.
REQ-006 SHALL have port b_valid / b_ready  input / output  1 / 1  handshake for requester B (load write-back).
REQ-007 SHALL have port b_rd / b_data  input  `NumRegsWidth / `RegWidth  B's destination register and value.
REQ-008 SHALL have port wr_en / wr_rd / wr_data  output  1 / `NumRegsWidth / `RegWidth  registered drive of the register file's write_en, rd and reg_in.
REQ-009 SHALL have port busy  output  `NumRegs  bit i set while any accepted write to register i has not yet been driven on wr_*.

Function
REQ-010 SHALL hold one accepted request per requester in a private holding slot; x_ready = slot x empty, or slot x granted this cycle.
REQ-011 SHALL accept a request when x_valid and x_ready are both high at a rising edge; if x_valid drops without acceptance, nothing is accepted.
REQ-012 SHALL grant at most one occupied slot per cycle; the grant is loaded into wr_* at the next edge (wr_en=1), giving a one-cycle latency from acceptance to wr_en.
REQ-013 SHALL hold wr_en=0 in cycles with no grant; wr_rd and wr_data keep their last values.
REQ-014 SHALL give A fixed priority when both slots are occupied, except as in REQ-015 and REQ-016.
REQ-015 SHALL grant B when starve_cnt equals STARVE_LIMIT; starve_cnt increments each cycle B is occupied and not granted, and clears when B is granted or its slot is empty.
REQ-016 SHALL grant the earlier-accepted slot first when both slots target the same rd; for simultaneous acceptance, A counts as earlier.
REQ-017 SHALL, when a single slot is occupied, grant it without waiting.
REQ-018 SHALL compute busy combinationally as OR of decode(slot A rd), decode(slot B rd) and decode(wr_rd) when wr_en is high; a register remains busy until no such source covers it.
REQ-019 SHALL allow a slot to be emptied and refilled in the same cycle (back-to-back throughput of one write per cycle per requester when uncontended).
REQ-020 SHALL not modify or drop data; every accepted request appears exactly once on wr_*.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear both slots, the order flag, starve_cnt, wr_en, wr_rd and wr_data to 0; busy reads 0, and a_ready and b_ready read 1.
REQ-022 SHALL discard any slot contents when reset is asserted mid-operation; no write occurs on the first edge after rst_n rises unless a request was accepted on it.

Configuration
REQ-023 SHALL include the starvation guard (REQ-015, starve_cnt) only when macro REG_WRITE_ARB_STARVE_EN is defined; without it, REQ-015 is removed, A always wins except under REQ-016, and STARVE_LIMIT is unused.

Verification
REQ-024 SHALL test single request: A writes r3=0x1234 -> wr_en=1, wr_rd=3, wr_data=0x1234 one cycle later; busy[3] is high for exactly two cycles.
REQ-025 SHALL test contention: A (r1=0xA) and B (r2=0xB) accepted in the same cycle -> r1 is written in cycle n+1 and r2 in n+2; b_ready is low in cycle n+1.
REQ-026 SHALL test same rd: B accepted with r5=0x1, then A accepted with r5=0x2 the next cycle while B is still held -> r5 is written with 0x1 before 0x2.
REQ-027 SHALL test starvation with the macro defined and STARVE_LIMIT=4: A is valid continuously and B is held -> B is granted on its 5th waiting cycle; without the macro, B waits until A deasserts.
REQ-028 SHALL test reset while both slots are occupied: rst_n low for one cycle -> wr_en=0, busy=0 and both ready signals high immediately; the held writes never appear.
